// File: rtl/fifo_wr_framer_pkg.sv
// Shared types and trailer-field helpers for fifo_wr_framer.
// Contents: FSM state enum and the trailer field layout: the truncation flag
// bit position and the width of the length field.
package fifo_wr_framer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        DROP  = 2'd2,
        TRAIL = 2'd3
    } state_e;

    // Bit position of the truncation flag in the trailer word.
    function automatic int unsigned trunc_pos(input int unsigned width);
        return width - 1;
    endfunction

    // Width of the beat-count field in the trailer word (must hold MAX_LEN).
    function automatic int unsigned len_width(input int unsigned max_len);
        return $clog2(max_len) + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_framer.sv
// Frames an upstream beat stream into the write port of a dual-clock FIFO.
// Each frame is written as its data beats (capped at MAX_LEN) followed by one
// trailer word {trunc flag, zeros, beat count}. A frame only starts when the
// FIFO reports room for a full frame plus trailer.
// Ports:
//   wr_clk_i, wr_rst_n_i          write-domain clock, async active-low reset
//   s_valid_i/s_data_i/s_last_i   upstream beat; s_ready_o accepts it
//   wr_en_o/wr_data_o             registered FIFO write strobe and data
//   wr_full_i/wr_free_i           FIFO full flag and free word count
//   trunc_o                       one-cycle pulse when a frame is truncated
//   err_o                         sticky: write issued while FIFO full
//   frame_cnt_o                   frames committed, wrapping 16-bit count
module fifo_wr_framer
    import fifo_wr_framer_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned MAX_LEN = 4
) (
    input  logic                   wr_clk_i,
    input  logic                   wr_rst_n_i,
    input  logic                   s_valid_i,
    input  logic [WIDTH-1:0]       s_data_i,
    input  logic                   s_last_i,
    output logic                   s_ready_o,
    output logic                   wr_en_o,
    output logic [WIDTH-1:0]       wr_data_o,
    input  logic                   wr_full_i,
    input  logic [$clog2(DEPTH):0] wr_free_i,
    output logic                   trunc_o,
    output logic                   err_o,
    output logic [15:0]            frame_cnt_o
);

    localparam int unsigned LEN_W     = len_width(MAX_LEN);
    localparam int unsigned TRUNC_POS = trunc_pos(WIDTH);
    localparam int unsigned FREE_W    = $clog2(DEPTH) + 1;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               tflag_q, tflag_d;
    logic               ready_q, ready_d;
    logic               wr_en_q, wr_en_d;
    logic [WIDTH-1:0]   wr_data_q, wr_data_d;
    logic               trunc_q, trunc_d;
    logic               err_q, err_d;
    logic [15:0]        cnt_q, cnt_d;

    logic               accept_c;
    logic [LEN_W-1:0]   len_inc_c;
    logic [WIDTH-1:0]   trailer_c;

    assign accept_c  = s_valid_i & ready_q;
    assign len_inc_c = len_q + LEN_W'(1);

    // Trailer word: truncation flag on top, beat count in the low bits.
    always_comb begin
        trailer_c                = '0;
        trailer_c[LEN_W-1:0]     = len_q;
        trailer_c[TRUNC_POS]     = tflag_q;
    end

    // State register and all registered outputs.
    always_ff @(posedge wr_clk_i or negedge wr_rst_n_i) begin
        if (!wr_rst_n_i) begin
            state_q   <= IDLE;
            len_q     <= '0;
            tflag_q   <= 1'b0;
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            trunc_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            tflag_q   <= tflag_d;
            ready_q   <= ready_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            trunc_q   <= trunc_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        tflag_d   = tflag_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        trunc_d   = 1'b0;
        cnt_d     = cnt_q;
        err_d     = err_q | (wr_en_q & wr_full_i);

        unique case (state_q)
            IDLE: begin
                // Wait for the previous trailer to land so wr_free_i reflects it.
                if (s_valid_i && !wr_en_q && (wr_free_i >= FREE_W'(MAX_LEN + 1))) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (accept_c) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = s_data_i;
                    len_d     = len_inc_c;
                    if (s_last_i) begin
                        state_d = TRAIL;
                        tflag_d = 1'b0;
                    end else if (len_inc_c == LEN_W'(MAX_LEN)) begin
                        state_d = DROP;
                        tflag_d = 1'b1;
                        trunc_d = 1'b1;
                    end
                end
            end
            DROP: begin
                if (accept_c && s_last_i) begin
                    state_d = TRAIL;
                end
            end
            TRAIL: begin
                wr_en_d   = 1'b1;
                wr_data_d = trailer_c;
                cnt_d     = cnt_q + 16'd1;
                len_d     = '0;
                tflag_d   = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == DATA) || (state_d == DROP);
    end

    assign s_ready_o   = ready_q;
    assign wr_en_o     = wr_en_q;
    assign wr_data_o   = wr_data_q;
    assign trunc_o     = trunc_q;
    assign err_o       = err_q;
    assign frame_cnt_o = cnt_q;

endmodule

// File: tb/tb_fifo_wr_framer.sv
// Self-checking bench for fifo_wr_framer: expected FIFO writes are queued as
// stimulus is issued and a monitor pops/compares each observed write.
module tb_fifo_wr_framer;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned MAX_LEN = 4;

    logic                   wr_clk_i;
    logic                   wr_rst_n_i;
    logic                   s_valid_i;
    logic [WIDTH-1:0]       s_data_i;
    logic                   s_last_i;
    logic                   s_ready_o;
    logic                   wr_en_o;
    logic [WIDTH-1:0]       wr_data_o;
    logic                   wr_full_i;
    logic [$clog2(DEPTH):0] wr_free_i;
    logic                   trunc_o;
    logic                   err_o;
    logic [15:0]            frame_cnt_o;

    int compared   = 0;
    int mismatched = 0;
    logic [WIDTH-1:0] exp_q[$];

    fifo_wr_framer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
        .wr_clk_i    (wr_clk_i),
        .wr_rst_n_i  (wr_rst_n_i),
        .s_valid_i   (s_valid_i),
        .s_data_i    (s_data_i),
        .s_last_i    (s_last_i),
        .s_ready_o   (s_ready_o),
        .wr_en_o     (wr_en_o),
        .wr_data_o   (wr_data_o),
        .wr_full_i   (wr_full_i),
        .wr_free_i   (wr_free_i),
        .trunc_o     (trunc_o),
        .err_o       (err_o),
        .frame_cnt_o (frame_cnt_o)
    );

    initial wr_clk_i = 1'b0;
    always #5 wr_clk_i = ~wr_clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every FIFO write must match the head of the expected queue.
    always @(negedge wr_clk_i) begin
        if (wr_rst_n_i && wr_en_o) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: got 0x%0h expected none at %0t", wr_data_o, $time);
            end else begin
                check("wr_data", 32'(wr_data_o), 32'(exp_q.pop_front()));
            end
        end
    end

    // Present one beat from a negedge and return at the negedge after acceptance.
    task automatic beat(input logic [WIDTH-1:0] d, input logic l);
        int n;
        n = 0;
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_last_i  = l;
        while (!s_ready_o && n < 50) begin
            @(negedge wr_clk_i);
            n++;
        end
        if (n >= 50) check("beat_timeout", 32'(s_ready_o), 32'd1);
        @(negedge wr_clk_i);
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    // Wait for all queued writes to be observed, bounded.
    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge wr_clk_i);
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        @(negedge wr_clk_i);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(s_ready_o),   32'd0);
        check({tag, "_wr_en"}, 32'(wr_en_o),     32'd0);
        check({tag, "_data"},  32'(wr_data_o),   32'd0);
        check({tag, "_trunc"}, 32'(trunc_o),     32'd0);
        check({tag, "_err"},   32'(err_o),       32'd0);
        check({tag, "_cnt"},   32'(frame_cnt_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        wr_rst_n_i = 1'b0;
        s_valid_i  = 1'b0;
        s_data_i   = '0;
        s_last_i   = 1'b0;
        wr_full_i  = 1'b0;
        wr_free_i  = 4'd8;
        repeat (3) @(negedge wr_clk_i);
        check_reset_vals("rst");
        wr_rst_n_i = 1'b1;
        @(negedge wr_clk_i);

        // Three-beat frame: data then trailer len=3.
        exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
        exp_q.push_back(8'hA3); exp_q.push_back(8'h03);
        beat(8'hA1, 1'b0);
        beat(8'hA2, 1'b0);
        beat(8'hA3, 1'b1);
        drain();
        check("cnt_A", 32'(frame_cnt_o), 32'd1);

        // Insufficient free space holds off the frame until free reaches 5.
        wr_free_i = 4'd4;
        s_valid_i = 1'b1;
        s_data_i  = 8'hF1;
        s_last_i  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge wr_clk_i);
            check("ready_low_free4", 32'(s_ready_o), 32'd0);
        end
        wr_free_i = 4'd5;
        @(negedge wr_clk_i);
        check("ready_free5", 32'(s_ready_o), 32'd1);
        exp_q.push_back(8'hF1); exp_q.push_back(8'h01);
        beat(8'hF1, 1'b1);
        drain();
        wr_free_i = 4'd8;
        check("cnt_F", 32'(frame_cnt_o), 32'd2);

        // Six-beat frame truncated after four beats.
        exp_q.push_back(8'hB1); exp_q.push_back(8'hB2);
        exp_q.push_back(8'hB3); exp_q.push_back(8'hB4);
        exp_q.push_back(8'h84);
        beat(8'hB1, 1'b0);
        check("trunc_B1", 32'(trunc_o), 32'd0);
        beat(8'hB2, 1'b0);
        beat(8'hB3, 1'b0);
        beat(8'hB4, 1'b0);
        check("trunc_B4", 32'(trunc_o), 32'd1);
        beat(8'hB5, 1'b0);
        check("trunc_B5", 32'(trunc_o), 32'd0);
        check("wr_en_B5", 32'(wr_en_o), 32'd0);
        beat(8'hB6, 1'b1);
        drain();
        check("cnt_B", 32'(frame_cnt_o), 32'd3);

        // Upstream gap mid-frame: no writes, ready held, length preserved.
        exp_q.push_back(8'hC1); exp_q.push_back(8'hC2); exp_q.push_back(8'h02);
        beat(8'hC1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge wr_clk_i);
            check("gap_ready", 32'(s_ready_o), 32'd1);
            check("gap_wr_en", 32'(wr_en_o), 32'd0);
        end
        beat(8'hC2, 1'b1);
        check("C2_latency", 32'(wr_en_o), 32'd1);
        @(negedge wr_clk_i);
        check("trailer_latency", 32'(wr_en_o), 32'd1);
        drain();
        check("cnt_C", 32'(frame_cnt_o), 32'd4);

        // Write while full sets sticky error.
        check("err_before", 32'(err_o), 32'd0);
        wr_full_i = 1'b1;
        exp_q.push_back(8'hE1); exp_q.push_back(8'h01);
        beat(8'hE1, 1'b1);
        drain();
        wr_full_i = 1'b0;
        check("err_set", 32'(err_o), 32'd1);
        repeat (3) @(negedge wr_clk_i);
        check("err_sticky", 32'(err_o), 32'd1);
        check("cnt_E", 32'(frame_cnt_o), 32'd5);

        // Reset mid-frame abandons it; next frame starts clean.
        exp_q.push_back(8'h71); exp_q.push_back(8'h72);
        beat(8'h71, 1'b0);
        beat(8'h72, 1'b0);
        @(negedge wr_clk_i);
        check("pre_rst_queue", 32'(exp_q.size()), 32'd0);
        wr_rst_n_i = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge wr_clk_i);
        wr_rst_n_i = 1'b1;
        @(negedge wr_clk_i);
        exp_q.push_back(8'hD1); exp_q.push_back(8'h01);
        beat(8'hD1, 1'b1);
        drain();
        check("cnt_D", 32'(frame_cnt_o), 32'd1);
        check("err_D", 32'(err_o), 32'd0);

        repeat (3) @(negedge wr_clk_i);
        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
